alu16_muldiv_seq: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer that drives the existing 16-bit ripple ALU as its only adder/subtractor. It computes 16×16→32 multiply by shift-add and 16÷16 divide by restoring division, one ALU pass per cycle. It sits beside the ALU in the CPU datapath and owns the ALU's inputs while Busy is high. The CPU control unit starts it and waits on Done.

---
 rtl/alu16_muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_alu16_muldiv_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_muldiv_seq.sv
// alu16_muldiv_seq
// Multi-cycle unsigned multiply/divide sequencer driving an external 16-bit
// ripple ALU as its only adder/subtractor. 16x16->32 shift-add multiply and
// 16/16 restoring divide, one ALU pass per cycle for 16 cycles.
//
// Ports
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Start, Mode         request pulse (IDLE only); 0 = multiply, 1 = divide
//   OpA, OpB            multiplicand/dividend, multiplier/divisor
//   Busy, Done          operation in progress; one-cycle completion pulse
//   Hi, Lo              product[31:16]/remainder, product[15:0]/quotient
//   DivZero             divide with OpB = 0 (set with Done)
//   ALU_A, ALU_B        ALU operand drive (zero outside RUN)
//   ALU_BNegate         0 = add, 1 = subtract
//   ALU_Op, ALU_Shamt   constant OP_ADD and 0
//   ALU_Out, ALU_CarryOut  ALU result and carry (sub: 1 means A >= B)
module alu16_muldiv_seq (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Mode,
  input  logic [15:0] OpA,
  input  logic [15:0] OpB,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Hi,
  output logic [15:0] Lo,
  output logic        DivZero,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic        ALU_BNegate,
  output logic [2:0]  ALU_Op,
  output logic [3:0]  ALU_Shamt,
  input  logic [15:0] ALU_Out,
  input  logic        ALU_CarryOut
);

  localparam logic [2:0] OP_ADD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        mode_q;
  logic [15:0] hi_q;   // multiply: upper product half; divide: partial remainder R
  logic [15:0] lo_q;   // multiply: lower product half; divide: quotient Q
  logic [15:0] m_q;    // multiplier M or divisor D
  logic        dz_q;
  logic        load;
  logic        div_zero_req;
  logic [16:0] s;
  logic        ok;

  // R always stays below D, so its 17th bit is zero between iterations and
  // only the shifted-out bit of S needs the extra position.
  assign s            = {hi_q, lo_q[15]};
  assign ok           = s[16] | ALU_CarryOut;
  assign div_zero_req = Mode && (OpB == '0);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    Busy        = 1'b0;
    Done        = 1'b0;
    load        = 1'b0;
    ALU_A       = '0;
    ALU_B       = '0;
    ALU_BNegate = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = div_zero_req ? DONE : RUN;
        end
      end
      RUN: begin
        Busy        = 1'b1;
        ALU_A       = mode_q ? s[15:0] : hi_q;
        ALU_B       = m_q;
        ALU_BNegate = mode_q;
        if (cnt == 4'd15) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      dz_q   <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      mode_q <= Mode;
      m_q    <= OpB;
      if (div_zero_req) begin
        hi_q <= OpA;
        lo_q <= '1;
        dz_q <= 1'b1;
      end else begin
        hi_q <= '0;
        lo_q <= OpA;
        dz_q <= 1'b0;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 4'd1;
      if (mode_q) begin
        if (ok) begin
          hi_q <= ALU_Out;
          lo_q <= {lo_q[14:0], 1'b1};
        end else begin
          hi_q <= s[15:0];
          lo_q <= {lo_q[14:0], 1'b0};
        end
      end else begin
        if (lo_q[0]) begin
          hi_q <= {ALU_CarryOut, ALU_Out[15:1]};
          lo_q <= {ALU_Out[0], lo_q[15:1]};
        end else begin
          hi_q <= {1'b0, hi_q[15:1]};
          lo_q <= {hi_q[0], lo_q[15:1]};
        end
      end
    end
  end

  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivZero   = dz_q;
  assign ALU_Op    = OP_ADD;
  assign ALU_Shamt = '0;

endmodule

// File: tb/tb_alu16_muldiv_seq.sv
module tb_alu16_muldiv_seq;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Mode;
  logic [15:0] OpA, OpB;
  logic        Busy, Done, DivZero, ALU_BNegate;
  logic [15:0] Hi, Lo, ALU_A, ALU_B, ALU_Out;
  logic [2:0]  ALU_Op;
  logic [3:0]  ALU_Shamt;
  logic        ALU_CarryOut;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  // Behavioural 16-bit ALU adder path: A + B or A + ~B + 1, carry out of bit 15.
  logic [16:0] alu_sum;
  assign alu_sum      = {1'b0, ALU_A} + (ALU_BNegate ? ({1'b0, ~ALU_B} + 17'd1) : {1'b0, ALU_B});
  assign ALU_Out      = alu_sum[15:0];
  assign ALU_CarryOut = alu_sum[16];

  alu16_muldiv_seq dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivZero(DivZero),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_BNegate(ALU_BNegate), .ALU_Op(ALU_Op),
    .ALU_Shamt(ALU_Shamt), .ALU_Out(ALU_Out), .ALU_CarryOut(ALU_CarryOut)
  );

  // Reference: plain arithmetic on the operands.
  function automatic logic [48:0] ref_model(input logic m, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] h, l;
    logic        dz;
    logic [4:0]  lat;
    if (m && b == 16'd0) begin
      h = a; l = 16'hFFFF; dz = 1'b1; lat = 5'd1;
    end else if (m) begin
      h = a % b; l = a / b; dz = 1'b0; lat = 5'd17;
    end else begin
      p = 32'(a) * 32'(b);
      h = p[31:16]; l = p[15:0]; dz = 1'b0; lat = 5'd17;
    end
    return {11'd0, lat, dz, h, l};
  endfunction

  // Launch one operation from an IDLE negedge; report results captured in the
  // Done cycle, the cycle index of Done, and how many cycles Busy was high.
  // Returns at the negedge of the cycle following Done.
  task automatic run_op(input logic m, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] hi, output logic [15:0] lo, output logic dz,
                        output int done_k, output int busy_n);
    hi = 'x; lo = 'x; dz = 1'bx; done_k = 0; busy_n = 0;
    Mode = m; OpA = a; OpB = b; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Mode = 1'($urandom); OpA = 16'($urandom); OpB = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_k = k; hi = Hi; lo = Lo; dz = DivZero;
        break;
      end
      @(negedge Clock);
    end
    @(negedge Clock);
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; OpA = '0; OpB = '0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({Busy, Done, Hi, Lo, DivZero, ALU_A, ALU_B, ALU_BNegate} !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h dz=%b a=%h b=%h neg=%b, want all 0",
               Busy, Done, Hi, Lo, DivZero, ALU_A, ALU_B, ALU_BNegate);
    end
    checks++;
    if (ALU_Op !== 3'b010 || ALU_Shamt !== 4'd0) begin
      errors++;
      $display("FAIL reset_alu_consts: got op=%b shamt=%h, want op=010 shamt=0", ALU_Op, ALU_Shamt);
    end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_directed;
    logic [15:0] ta[5] = '{16'd3, 16'hFFFF, 16'd100, 16'hFFFF, 16'h1234};
    logic [15:0] tb[5] = '{16'd5, 16'hFFFF, 16'd7,   16'h8001, 16'h0000};
    logic        tm[5] = '{1'b0,  1'b0,     1'b1,    1'b1,     1'b1};
    logic [15:0] xh[5] = '{16'h0000, 16'hFFFE, 16'h0002, 16'h7FFE, 16'h1234};
    logic [15:0] xl[5] = '{16'h000F, 16'h0001, 16'h000E, 16'h0001, 16'hFFFF};
    logic        xd[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          xk[5] = '{17, 17, 17, 17, 1};
    int          xb[5] = '{16, 16, 16, 16, 0};
    logic [15:0] hi, lo;
    logic        dz;
    int          dk, bn;
    for (int i = 0; i < 5; i++) begin
      run_op(tm[i], ta[i], tb[i], hi, lo, dz, dk, bn);
      checks++;
      if (hi !== xh[i] || lo !== xl[i] || dz !== xd[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                 i, hi, lo, dz, xh[i], xl[i], xd[i]);
      end
      checks++;
      if (dk != xk[i] || bn != xb[i]) begin
        errors++;
        $display("FAIL directed_timing[%0d]: got done_at=%0d busy_cycles=%0d, want %0d %0d",
                 i, dk, bn, xk[i], xb[i]);
      end
      // One cycle after Done: back in IDLE, results held, ALU idle.
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Hi !== xh[i] || Lo !== xl[i] || DivZero !== xd[i] ||
          ALU_A !== 16'd0 || ALU_B !== 16'd0 || ALU_BNegate !== 1'b0) begin
        errors++;
        $display("FAIL directed_hold[%0d]: got done=%b busy=%b hi=%h lo=%h dz=%b a=%h b=%h neg=%b, want 0 0 %h %h %b 0 0 0",
                 i, Done, Busy, Hi, Lo, DivZero, ALU_A, ALU_B, ALU_BNegate, xh[i], xl[i], xd[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int done_k = 0;
    int busy_n = 0;
    Mode = 1'b0; OpA = 16'd300; OpB = 16'd77; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (Busy) busy_n++;
      if (Done && done_k == 0) done_k = k;
      if (k == 3 || k == 17) begin
        Start = 1'b1; Mode = 1'b1; OpA = 16'hAAAA; OpB = 16'd0;
      end
      @(negedge Clock);
      Start = 1'b0;
    end
    checks++;
    if (done_k != 17 || busy_n != 16 || Hi !== 16'd0 || Lo !== 16'd23100 || DivZero !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: got done_at=%0d busy=%0d hi=%h lo=%h dz=%b, want 17 16 0000 5a3c 0",
               done_k, busy_n, Hi, Lo, DivZero);
    end
    // Cycle N+18: IDLE, a new Start is accepted.
    Mode = 1'b0; OpA = 16'd2; OpB = 16'd2; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Hi !== 16'd0 || Lo !== 16'd2) begin
      errors++;
      $display("FAIL start_after_done: got busy=%b hi=%h lo=%h, want busy=1 hi=0000 lo=0002", Busy, Hi, Lo);
    end
    repeat (20) @(negedge Clock);
  endtask

  task automatic test_reset_mid;
    int          seen_done = 0;
    logic [15:0] hi, lo;
    logic        dz;
    int          dk, bn;
    Mode = 1'b1; OpA = 16'd5000; OpB = 16'd3; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (7) @(negedge Clock);
    Reset = 1'b1;   // high in cycle N+8
    @(negedge Clock);
    Reset = 1'b0;
    checks++;
    if ({Busy, Done, Hi, Lo, DivZero, ALU_A, ALU_B, ALU_BNegate} !== 52'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b hi=%h lo=%h dz=%b a=%h b=%h neg=%b, want all 0",
               Busy, Done, Hi, Lo, DivZero, ALU_A, ALU_B, ALU_BNegate);
    end
    for (int k = 0; k < 20; k++) begin
      if (Done || Busy) seen_done++;
      @(negedge Clock);
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d busy/done cycles after reset, want 0", seen_done);
    end
    run_op(1'b1, 16'd200, 16'd10, hi, lo, dz, dk, bn);
    checks++;
    if (hi !== 16'd0 || lo !== 16'd20 || dz !== 1'b0 || dk != 17) begin
      errors++;
      $display("FAIL reset_mid_fresh_div: got hi=%h lo=%h dz=%b done_at=%0d, want 0000 0014 0 17", hi, lo, dz, dk);
    end
  endtask

  // Random operations launched back to back: each starts in the first IDLE cycle.
  task automatic test_back_to_back;
    logic [48:0] exp;
    logic [15:0] a, b, hi, lo;
    logic        m, dz;
    int          dk, bn;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'hFFFF;
        2:       b = 16'($urandom_range(1, 3));
        default: b = 16'($urandom);
      endcase
      exp = ref_model(m, a, b);
      run_op(m, a, b, hi, lo, dz, dk, bn);
      checks++;
      if (hi !== exp[31:16] || lo !== exp[15:0] || dz !== exp[32] ||
          dk != int'(exp[37:33]) || bn != ((exp[32] == 1'b1) ? 0 : 16)) begin
        errors++;
        $display("FAIL b2b[%0d] m=%b a=%h b=%h: got hi=%h lo=%h dz=%b done_at=%0d busy=%0d, want hi=%h lo=%h dz=%b done_at=%0d",
                 i, m, a, b, hi, lo, dz, dk, bn, exp[31:16], exp[15:0], exp[32], exp[37:33]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignored_start;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
